// File: rtl/uart_prog_loader_pkg.sv
// Shared protocol bytes and loader FSM encodings for the UART program loader.
package uart_prog_loader_pkg;

    localparam logic [7:0] HDR = 8'hA5;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN0  = 3'd1;
    localparam logic [2:0] ST_LEN1  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CHK   = 3'd4;
    localparam logic [2:0] ST_REPLY = 3'd5;

    // States in which a stalled sender can hold the loader; the inter-byte timer runs only here.
    function automatic logic in_frame(input logic [2:0] st);
        return (st == ST_LEN0) || (st == ST_LEN1) || (st == ST_DATA) || (st == ST_CHK);
    endfunction

endpackage

// File: rtl/uart_byte_fetch.sv
// Single-outstanding read handshake towards uart_comm; presents each byte with a valid pulse.
module uart_byte_fetch (
    input  logic       CLK,
    input  logic       RST,
    input  logic       en,
    input  logic       receivable,
    input  logic       recv_ack,
    input  logic [7:0] recv_data,
    output logic       recv_flag,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic pending_reg;
    logic issue;

    assign issue      = en && receivable && !pending_reg;
    // Acks that arrive with no read in flight (e.g. after a reset) are ignored.
    assign byte_valid = pending_reg && recv_ack;
    assign byte_data  = recv_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            recv_flag   <= 1'b0;
            pending_reg <= 1'b0;
        end else begin
            recv_flag <= issue;
            if (issue)
                pending_reg <= 1'b1;
            else if (recv_ack)
                pending_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Receives a framed program image over UART, writes it as little-endian words into memory
// and releases the core only after the frame checksum verifies.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              receivable,
    output logic              recv_flag,
    input  logic [7:0]        recv_data,
    input  logic              recv_ack,
    input  logic              sendable,
    output logic              send_flag,
    output logic [7:0]        send_data,
    input  logic              send_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]        state_reg;
    logic [7:0]        sum_reg;
    logic [15:0]       len_reg;
    logic [15:0]       word_idx_reg;
    logic [1:0]        lane_reg;
    logic [23:0]       word_reg;
    logic [7:0]        reply_reg;
    logic [TW-1:0]     timer_reg;

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic [7:0]        sum_next;
    logic              timer_active;
    logic              timeout_hit;
    logic              fetch_en;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] idx_a;

    assign sum_next     = sum_reg + byte_data;
    assign timer_active = in_frame(state_reg);
    // A byte arriving in the same cycle wins over the timeout, since it clears the timer.
    assign timeout_hit  = timer_active && !byte_valid && (timer_reg == TW'(TIMEOUT));
    assign fetch_en     = (state_reg != ST_REPLY) && !timeout_hit;
    assign base_a       = ADDR_W'(BASE_ADDR);
    assign idx_a        = ADDR_W'(word_idx_reg);

    uart_byte_fetch u_fetch (
        .CLK        (CLK),
        .RST        (RST),
        .en         (fetch_en),
        .receivable (receivable),
        .recv_ack   (recv_ack),
        .recv_data  (recv_data),
        .recv_flag  (recv_flag),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            sum_reg      <= '0;
            len_reg      <= '0;
            word_idx_reg <= '0;
            lane_reg     <= '0;
            word_reg     <= '0;
            reply_reg    <= '0;
            timer_reg    <= '0;
            send_flag    <= 1'b0;
            send_data    <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            if (!timer_active || byte_valid || timeout_hit)
                timer_reg <= '0;
            else
                timer_reg <= timer_reg + 1'b1;

            if (timeout_hit) begin
                load_err  <= 1'b1;
                reply_reg <= NAK;
                state_reg <= ST_REPLY;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (byte_valid && byte_data == HDR) begin
                            cpu_hold     <= 1'b1;
                            load_done    <= 1'b0;
                            load_err     <= 1'b0;
                            sum_reg      <= '0;
                            word_idx_reg <= '0;
                            lane_reg     <= '0;
                            state_reg    <= ST_LEN0;
                        end
                    end
                    ST_LEN0: begin
                        if (byte_valid) begin
                            len_reg[7:0] <= byte_data;
                            sum_reg      <= sum_next;
                            state_reg    <= ST_LEN1;
                        end
                    end
                    ST_LEN1: begin
                        if (byte_valid) begin
                            len_reg[15:8] <= byte_data;
                            sum_reg       <= sum_next;
                            state_reg     <= ({byte_data, len_reg[7:0]} == 16'd0) ? ST_CHK : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (byte_valid) begin
                            sum_reg  <= sum_next;
                            lane_reg <= lane_reg + 2'd1;
                            case (lane_reg)
                                2'd0:    word_reg[7:0]   <= byte_data;
                                2'd1:    word_reg[15:8]  <= byte_data;
                                2'd2:    word_reg[23:16] <= byte_data;
                                default: begin
                                    // Address wraps modulo 2^ADDR_W by construction.
                                    mem_we       <= 1'b1;
                                    mem_addr     <= base_a + idx_a;
                                    mem_wdata    <= {byte_data, word_reg};
                                    word_idx_reg <= word_idx_reg + 16'd1;
                                    if (word_idx_reg == len_reg - 16'd1)
                                        state_reg <= ST_CHK;
                                end
                            endcase
                        end
                    end
                    ST_CHK: begin
                        if (byte_valid) begin
                            if (sum_next == 8'h00) begin
                                reply_reg <= ACK;
                                load_done <= 1'b1;
                                cpu_hold  <= 1'b0;
                            end else begin
                                reply_reg <= NAK;
                                load_err  <= 1'b1;
                            end
                            state_reg <= ST_REPLY;
                        end
                    end
                    ST_REPLY: begin
                        if (!send_flag) begin
                            if (sendable) begin
                                send_flag <= 1'b1;
                                send_data <= reply_reg;
                            end
                        end else if (send_ack) begin
                            send_flag <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed and randomized frames against a queue-based model of the loader's observable behaviour.
module tb_uart_prog_loader;

    localparam int ADDR_W = 2;
    localparam int BASE   = 3;
    localparam int TMO    = 200;

    logic              CLK = 1'b0;
    logic              RST;
    logic              receivable;
    logic              recv_flag;
    logic [7:0]        recv_data;
    logic              recv_ack;
    logic              sendable;
    logic              send_flag;
    logic [7:0]        send_data;
    logic              send_ack;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  exp_reply;

    int errors = 0;
    int checks = 0;

    uart_prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .receivable (receivable),
        .recv_flag  (recv_flag),
        .recv_data  (recv_data),
        .recv_ack   (recv_ack),
        .sendable   (sendable),
        .send_flag  (send_flag),
        .send_data  (send_data),
        .send_ack   (send_ack),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 CLK = ~CLK;

    // uart_comm receive side: answers each read request after 0..2 cycles.
    initial begin
        int d;
        receivable = 1'b0;
        recv_ack   = 1'b0;
        recv_data  = 8'h00;
        forever begin
            @(negedge CLK);
            receivable = (rx_q.size() != 0);
            if (recv_flag) begin
                d = $urandom_range(0, 2);
                repeat (d) @(negedge CLK);
                recv_data = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
                recv_ack  = 1'b1;
                @(negedge CLK);
                recv_ack   = 1'b0;
                receivable = (rx_q.size() != 0);
            end
        end
    end

    // uart_comm send side: acknowledges a held request after 0..2 cycles.
    initial begin
        int d;
        send_ack = 1'b0;
        forever begin
            @(negedge CLK);
            if (send_flag) begin
                d = $urandom_range(0, 2);
                repeat (d) @(negedge CLK);
                tx_q.push_back(send_data);
                send_ack = 1'b1;
                @(negedge CLK);
                send_ack = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (mem_we) begin
            wr_addr_q.push_back(32'(mem_addr));
            wr_data_q.push_back(mem_wdata);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " recv_flag"}, 32'(recv_flag), 0);
        check({tag, " send_flag"}, 32'(send_flag), 0);
        check({tag, " send_data"}, 32'(send_data), 0);
        check({tag, " mem_we"},    32'(mem_we), 0);
        check({tag, " mem_addr"},  32'(mem_addr), 0);
        check({tag, " mem_wdata"}, mem_wdata, 0);
        check({tag, " cpu_hold"},  32'(cpu_hold), 1);
        check({tag, " load_done"}, 32'(load_done), 0);
        check({tag, " load_err"},  32'(load_err), 0);
    endtask

    // mode: 0 correct CHK, 1 corrupted CHK, 2 CHK forced to 0x00, 3 CHK omitted (sender stalls)
    task automatic push_frame(input logic [7:0] d[$], input int n, input int mode);
        int s;
        logic [7:0] c;
        logic [7:0] chk;
        logic [31:0] w;
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'(n % 256));
        rx_q.push_back(8'(n / 256));
        s = (n % 256) + (n / 256);
        foreach (d[i]) begin
            rx_q.push_back(d[i]);
            s += int'(d[i]);
        end
        for (int i = 0; i < d.size() / 4; i++) begin
            w = 32'(int'(d[4*i]) + 256 * int'(d[4*i+1]) + 65536 * int'(d[4*i+2]))
                + 32'(d[4*i+3]) * 32'd16777216;
            exp_addr_q.push_back(32'((BASE + i) % (1 << ADDR_W)));
            exp_data_q.push_back(w);
        end
        c = 8'((256 - (s % 256)) % 256);
        case (mode)
            1:       chk = c ^ 8'h5A;
            2:       chk = 8'h00;
            default: chk = c;
        endcase
        if (mode != 3) rx_q.push_back(chk);
        exp_reply = (mode != 3 && chk == c) ? 8'h06 : 8'h15;
    endtask

    task automatic finish_frame(input string tag, input int bound);
        int c;
        logic [31:0] got;
        bit ok;
        c = 0;
        while (tx_q.size() == 0 && c < bound) begin
            @(negedge CLK);
            c++;
        end
        got = (tx_q.size() != 0) ? 32'(tx_q.pop_front()) : 32'hDEAD;
        check({tag, " reply"}, got, 32'(exp_reply));
        repeat (3) @(negedge CLK);
        check({tag, " write count"}, wr_addr_q.size(), exp_addr_q.size());
        while (wr_addr_q.size() != 0 && exp_addr_q.size() != 0) begin
            check({tag, " addr"},  wr_addr_q.pop_front(), exp_addr_q.pop_front());
            check({tag, " wdata"}, wr_data_q.pop_front(), exp_data_q.pop_front());
        end
        ok = (exp_reply == 8'h06);
        check({tag, " cpu_hold"},  32'(cpu_hold), 32'(!ok));
        check({tag, " load_done"}, 32'(load_done), 32'(ok));
        check({tag, " load_err"},  32'(load_err), 32'(!ok));
        check({tag, " send_flag idle"}, 32'(send_flag), 0);
        wr_addr_q.delete(); wr_data_q.delete();
        exp_addr_q.delete(); exp_data_q.delete();
    endtask

    initial begin
        logic [7:0] d[$];
        int n;
        int c;
        int seen;

        RST = 1'b1;
        sendable = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset("reset");
        RST = 1'b0;
        @(negedge CLK);

        // T1: good single-word frame
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_frame(d, 1, 0);
        finish_frame("t1", 300);

        // T2: same frame, CHK=0x00 -> NAK, word still written
        push_frame(d, 1, 2);
        finish_frame("t2", 300);

        // T3: leading garbage then empty frame
        rx_q.push_back(8'h00);
        rx_q.push_back(8'hFF);
        d.delete();
        push_frame(d, 0, 0);
        finish_frame("t3", 300);

        // T5: two words wrap from address 3 to 0
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF0, 8'hE0, 8'hD0, 8'hC0};
        push_frame(d, 2, 0);
        finish_frame("t5", 300);

        // T4: reload after DONE re-asserts hold, then sender stalls mid-word
        d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h77};
        push_frame(d, 2, 3);
        repeat (30) @(negedge CLK);
        check("t4 hold during reload", 32'(cpu_hold), 1);
        check("t4 done cleared", 32'(load_done), 0);
        finish_frame("t4", TMO + 400);

        // T6: reply withheld while sendable=0
        sendable = 1'b0;
        d = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        push_frame(d, 1, 0);
        c = 0;
        while (rx_q.size() != 0 && c < 300) begin
            @(negedge CLK);
            c++;
        end
        repeat (5) @(negedge CLK);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (send_flag) seen++;
        end
        check("t6 send_flag while blocked", seen, 0);
        sendable = 1'b1;
        finish_frame("t6", 300);

        // Reset in the middle of DATA
        d.delete();
        for (int i = 0; i < 12; i++) d.push_back(8'($urandom));
        push_frame(d, 3, 0);
        c = 0;
        while (wr_addr_q.size() == 0 && c < 300) begin
            @(negedge CLK);
            c++;
        end
        check("mid-data first write seen", 32'(wr_addr_q.size() != 0), 1);
        RST = 1'b1;
        rx_q.delete();
        #1;
        check_reset("mid-data reset");
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        check("no reply after reset", tx_q.size(), 0);
        wr_addr_q.delete(); wr_data_q.delete();
        exp_addr_q.delete(); exp_data_q.delete();
        tx_q.delete();

        // Randomized frames
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 3);
            d.delete();
            for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
            push_frame(d, n, ($urandom_range(0, 2) == 0) ? 1 : 0);
            finish_frame($sformatf("rand%0d", r), 400);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
